rf_scoreboard: RTL and testbench
================================

# rf_scoreboard

Parametrised integer register file with a per-register pending-write scoreboard, for the pipelined successor of the single-cycle core. It serves a configurable number of combinational read ports and one writeback port, with optional write-to-read bypass. It tracks which architectural registers have an issued but not yet written-back result, so decode can stall on RAW and WAW hazards. Register 0 is hardwired to zero and is never busy.

## Interface
- XLEN, 32, data width in bits
- NREGS, 32, number of architectural registers (power of two, ≥ 2); AW = $clog2(NREGS)
- NRD, 2, number of read ports (1..4)
- BYPASS, 1, 1 = a same-cycle writeback is forwarded to matching read ports; 0 = reads see only stored state
- clk  in  1  single clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- id2rf_rs_addr_i  in  NRD*AW  packed read addresses; port k occupies bits [k*AW +: AW]
- rf2id_rs_data_o  out  NRD*XLEN  packed read data, same packing
- rf2id_rs_busy_o  out  NRD  bit k = register at port k has a pending write that is not satisfied this cycle
- id2rf_rd_wr_req_i  in  1  writeback request
- id2rf_rd_addr_i  in  AW  writeback destination
- id2rf_rd_data_i  in  XLEN  writeback data
- id2rf_issue_req_i  in  1  instruction issuing with a destination register
- id2rf_issue_addr_i  in  AW  issuing destination register
- rf2id_issue_stall_o  out  1  issue refused (WAW hazard); combinational
- rf2id_busy_cnt_o  out  AW+1  number of currently busy registers, registered

## Operation
- Storage: NREGS-1 registers of XLEN bits, plus busy[NREGS-1:1]; busy[0] is constant 0.
- wr_valid = id2rf_rd_wr_req_i & (id2rf_rd_addr_i != 0). Writes to x0 are dropped and do not affect busy.
- Read port k, address a:
  - a == 0: data = 0, busy = 0.
  - Else, if BYPASS == 1, wr_valid, and id2rf_rd_addr_i == a: data = id2rf_rd_data_i, busy = 0.
  - Otherwise: data = reg[a], busy = busy[a].
- The issue stall is combinational: stall = id2rf_issue_req_i & (id2rf_issue_addr_i != 0) & busy[id2rf_issue_addr_i] & ~(wr_valid & id2rf_rd_addr_i == id2rf_issue_addr_i).
- Issue accepted: iss_ok = id2rf_issue_req_i & (id2rf_issue_addr_i != 0) & ~stall. An issue to x0 is accepted and has no effect.
- Busy update on each edge, for each register r:
  - Set if iss_ok and issue address == r.
  - Else cleared if wr_valid and rd address == r.
  - Else held.
  - When set and clear target the same register in one cycle, set wins: the old result retires and the new issue is pending.
- A write to a non-busy register is legal. The data is stored and busy stays 0.
- rf2id_busy_cnt_o next value = current + iss_ok_sets_new − clears_of_busy. Both terms are counted only when the busy bit actually changes, so a set+clear on the same register gives net 0. The count never exceeds NREGS-1 and never underflows.
- When BYPASS == 0, busy for a port matching the writeback is still busy[a], which is the pre-write value.

## Timing
- Reset (synchronous): all registers = 0, all busy = 0, rf2id_busy_cnt_o = 0.
  - rf2id_issue_stall_o = 0 and all rf2id_rs_busy_o = 0 in the cycle after reset is sampled.
  - Reset takes priority over a simultaneous write or issue; both are discarded.
- Reads and stall have zero latency (combinational from inputs and state).
- A write in cycle n is visible from stored state in cycle n+1, and also in cycle n when BYPASS == 1.
- An issue accepted in cycle n makes busy visible in cycle n+1.
- A writeback in cycle n clears busy, visible in cycle n+1, or in cycle n on read ports when BYPASS == 1.
- No combinational path from rf2id_issue_stall_o back into any input is required. The stall depends only on the issue inputs, the writeback inputs and state.

## Test plan
- Reset, then read x0..x31 on all ports -> all data 0, all busy 0, busy_cnt 0. Write x0 = 0xDEADBEEF -> x0 still reads 0.
- Write x5 = 0x12345678 with port0 reading x5 in the same cycle -> BYPASS=1: port0 = 0x12345678 immediately. BYPASS=0: old value 0 that cycle, 0x12345678 the next.
- Issue x7 -> busy port shows x7 busy next cycle, busy_cnt = 1. Issue x7 again -> stall = 1, busy_cnt stays 1. Write x7 = 0xA5 -> busy clears, busy_cnt = 0, x7 reads 0xA5.
- x9 busy. In the same cycle, write x9 = 0x11 and issue x9 -> stall = 0, x9 busy next cycle, busy_cnt unchanged, x9 reads 0x11.
- Issue x1..x31 back-to-back -> busy_cnt reaches 31. Assert reset with a write pending -> next cycle all busy 0, busy_cnt 0, registers 0.
- NRD=4: four ports read x3, x3, x0 and x31 with x3 = 0x33 and x31 = 0xFFFFFFFF -> outputs 0x33, 0x33, 0, 0xFFFFFFFF.

Source files
------------

// File: rtl/rf_scoreboard_if.sv
// Decode <-> register file bundle: read ports, writeback,
// issue request and scoreboard status.
interface rf_scoreboard_if #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NRD   = 2
);
    localparam int AW = $clog2(NREGS);

    logic [NRD*AW-1:0]   id2rf_rs_addr_i;
    logic [NRD*XLEN-1:0] rf2id_rs_data_o;
    logic [NRD-1:0]      rf2id_rs_busy_o;
    logic                id2rf_rd_wr_req_i;
    logic [AW-1:0]       id2rf_rd_addr_i;
    logic [XLEN-1:0]     id2rf_rd_data_i;
    logic                id2rf_issue_req_i;
    logic [AW-1:0]       id2rf_issue_addr_i;
    logic                rf2id_issue_stall_o;
    logic [AW:0]         rf2id_busy_cnt_o;

    modport master (
        output id2rf_rs_addr_i,
        output id2rf_rd_wr_req_i,
        output id2rf_rd_addr_i,
        output id2rf_rd_data_i,
        output id2rf_issue_req_i,
        output id2rf_issue_addr_i,
        input  rf2id_rs_data_o,
        input  rf2id_rs_busy_o,
        input  rf2id_issue_stall_o,
        input  rf2id_busy_cnt_o
    );

    modport slave (
        input  id2rf_rs_addr_i,
        input  id2rf_rd_wr_req_i,
        input  id2rf_rd_addr_i,
        input  id2rf_rd_data_i,
        input  id2rf_issue_req_i,
        input  id2rf_issue_addr_i,
        output rf2id_rs_data_o,
        output rf2id_rs_busy_o,
        output rf2id_issue_stall_o,
        output rf2id_busy_cnt_o
    );
endinterface

// File: rtl/rf_scoreboard.sv
// Integer register file with per-register pending-write scoreboard,
// NRD combinational read ports, one writeback port, optional bypass.
module rf_scoreboard #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int NRD    = 2,
    parameter int BYPASS = 1
) (
    input logic            clk,
    input logic            reset,
    rf_scoreboard_if.slave rf
);
    localparam int AW = $clog2(NREGS);

    logic [XLEN-1:0]  regs_q [NREGS];
    logic [NREGS-1:0] busy_q;
    logic [AW:0]      cnt_q;

    logic            wr_valid;
    logic [AW-1:0]   wr_addr;
    logic [XLEN-1:0] wr_data;
    logic            iss_nz;
    logic [AW-1:0]   iss_addr;
    logic            iss_wr_hit;
    logic            stall;
    logic            iss_ok;
    logic            set_new;
    logic            clr_old;

    logic [XLEN-1:0] rd_data [NRD];
    logic [NRD-1:0]  rd_busy;

    assign wr_addr  = rf.id2rf_rd_addr_i;
    assign wr_data  = rf.id2rf_rd_data_i;
    assign wr_valid = rf.id2rf_rd_wr_req_i && (wr_addr != '0);
    assign iss_addr = rf.id2rf_issue_addr_i;
    assign iss_nz   = rf.id2rf_issue_req_i && (iss_addr != '0);

    // A writeback retiring the same register lets the new issue through.
    assign iss_wr_hit = wr_valid && (wr_addr == iss_addr);
    assign stall      = iss_nz && busy_q[iss_addr] && !iss_wr_hit;
    assign iss_ok     = iss_nz && !stall;

    // Count only real bit transitions; set wins over clear on one register.
    assign set_new = iss_ok && !busy_q[iss_addr];
    assign clr_old = wr_valid && busy_q[wr_addr]
                     && !(iss_ok && iss_wr_hit);

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0] a;
        logic          nz;
        logic          hit;

        assign a   = rf.id2rf_rs_addr_i[k*AW +: AW];
        assign nz  = (a != '0);
        assign hit = (BYPASS != 0) && wr_valid && (wr_addr == a);

        assign rd_data[k] = !nz ? '0 :
                            hit ? wr_data :
                                  regs_q[a];
        assign rd_busy[k] = nz && !hit && busy_q[a];
    end

    always_comb begin
        rf.rf2id_rs_data_o = '0;
        for (int k = 0; k < NRD; k++) begin
            rf.rf2id_rs_data_o[k*XLEN +: XLEN] = rd_data[k];
        end
    end

    assign rf.rf2id_rs_busy_o     = rd_busy;
    assign rf.rf2id_issue_stall_o = stall;
    assign rf.rf2id_busy_cnt_o    = cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NREGS; r++) begin
                regs_q[r] <= '0;
            end
        end else if (wr_valid) begin
            regs_q[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= '0;
        end else begin
            busy_q[0] <= 1'b0;
            for (int r = 1; r < NREGS; r++) begin
                if (iss_ok && (iss_addr == AW'(r))) begin
                    busy_q[r] <= 1'b1;
                end else if (wr_valid && (wr_addr == AW'(r))) begin
                    busy_q[r] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + {{AW{1'b0}}, set_new}
                           - {{AW{1'b0}}, clr_old};
        end
    end
endmodule

// File: tb/tb_rf_scoreboard.sv
// Bench for rf_scoreboard: bypassing 4-port and non-bypassing
// 1-port instances checked against a shared behavioural model.
module tb_rf_scoreboard;
    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int AW    = 5;
    localparam int NRD   = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [NRD*AW-1:0] rs_addr;
    logic              wr_req;
    logic [AW-1:0]     wr_addr;
    logic [XLEN-1:0]   wr_data;
    logic              iss_req;
    logic [AW-1:0]     iss_addr;

    rf_scoreboard_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) bus_a ();
    rf_scoreboard_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(1))   bus_b ();

    assign bus_a.id2rf_rs_addr_i    = rs_addr;
    assign bus_a.id2rf_rd_wr_req_i  = wr_req;
    assign bus_a.id2rf_rd_addr_i    = wr_addr;
    assign bus_a.id2rf_rd_data_i    = wr_data;
    assign bus_a.id2rf_issue_req_i  = iss_req;
    assign bus_a.id2rf_issue_addr_i = iss_addr;
    assign bus_b.id2rf_rs_addr_i    = rs_addr[AW-1:0];
    assign bus_b.id2rf_rd_wr_req_i  = wr_req;
    assign bus_b.id2rf_rd_addr_i    = wr_addr;
    assign bus_b.id2rf_rd_data_i    = wr_data;
    assign bus_b.id2rf_issue_req_i  = iss_req;
    assign bus_b.id2rf_issue_addr_i = iss_addr;

    rf_scoreboard #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .BYPASS(1)) dut_a (
        .clk   (clk),
        .reset (reset),
        .rf    (bus_a)
    );

    rf_scoreboard #(.XLEN(XLEN), .NREGS(NREGS), .NRD(1), .BYPASS(0)) dut_b (
        .clk   (clk),
        .reset (reset),
        .rf    (bus_b)
    );

    logic [XLEN-1:0] m_reg [NREGS];
    bit              m_busy [NREGS];
    int checks = 0;
    int errors = 0;

    function automatic bit m_wrv();
        return wr_req && (wr_addr != 0);
    endfunction

    function automatic logic [XLEN-1:0] exp_data(input logic [AW-1:0] a, input bit byp);
        if (a == 0) return '0;
        if (byp && m_wrv() && wr_addr == a) return wr_data;
        return m_reg[a];
    endfunction

    function automatic logic exp_busy(input logic [AW-1:0] a, input bit byp);
        if (a == 0) return 1'b0;
        if (byp && m_wrv() && wr_addr == a) return 1'b0;
        return m_busy[a];
    endfunction

    function automatic logic exp_stall();
        return iss_req && iss_addr != 0 && m_busy[iss_addr]
               && !(m_wrv() && wr_addr == iss_addr);
    endfunction

    function automatic logic [AW:0] exp_cnt();
        int s = 0;
        for (int i = 0; i < NREGS; i++) s += int'(m_busy[i]);
        return (AW+1)'(s);
    endfunction

    function automatic logic [XLEN-1:0] a_data(input int k);
        return bus_a.rf2id_rs_data_o[k*XLEN +: XLEN];
    endfunction

    task automatic model_clock();
        bit ok;
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                m_reg[i]  = '0;
                m_busy[i] = 1'b0;
            end
        end else begin
            ok = iss_req && iss_addr != 0 && !exp_stall();
            if (m_wrv()) begin
                m_reg[wr_addr]  = wr_data;
                m_busy[wr_addr] = 1'b0;
            end
            if (ok) m_busy[iss_addr] = 1'b1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_clock();
        #1;
    endtask

    task automatic idle();
        wr_req  = 1'b0;
        iss_req = 1'b0;
    endtask

    task automatic set_all_ports(input logic [AW-1:0] a);
        for (int k = 0; k < NRD; k++) rs_addr[k*AW +: AW] = a;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle();
        rs_addr = '0;
        tick();
        tick();
        reset = 1'b0;
        for (int a = 0; a < NREGS; a++) begin
            set_all_ports(AW'(a));
            #2;
            for (int k = 0; k < NRD; k++) begin
                checks++;
                if (a_data(k) !== 32'h0 || bus_a.rf2id_rs_busy_o[k] !== 1'b0) begin
                    errors++;
                    $display("FAIL reset_read x%0d p%0d: got %h/%b want 0/0",
                             a, k, a_data(k), bus_a.rf2id_rs_busy_o[k]);
                end
            end
            checks++;
            if (bus_a.rf2id_busy_cnt_o !== 6'd0 || bus_a.rf2id_issue_stall_o !== 1'b0) begin
                errors++;
                $display("FAIL reset_cnt: got %0d/%b want 0/0",
                         bus_a.rf2id_busy_cnt_o, bus_a.rf2id_issue_stall_o);
            end
            tick();
        end
        wr_req  = 1'b1;
        wr_addr = 5'd0;
        wr_data = 32'hDEADBEEF;
        set_all_ports(5'd0);
        #2;
        checks++;
        if (a_data(0) !== 32'h0) begin
            errors++;
            $display("FAIL x0_write_bypass: got %h want 0", a_data(0));
        end
        tick();
        idle();
        #2;
        checks++;
        if (a_data(0) !== 32'h0 || bus_b.rf2id_rs_data_o !== 32'h0) begin
            errors++;
            $display("FAIL x0_write_stored: got %h/%h want 0",
                     a_data(0), bus_b.rf2id_rs_data_o);
        end
    endtask

    task automatic test_bypass();
        wr_req  = 1'b1;
        wr_addr = 5'd5;
        wr_data = 32'h12345678;
        set_all_ports(5'd5);
        #2;
        checks++;
        if (a_data(0) !== exp_data(5, 1)) begin
            errors++;
            $display("FAIL bypass_same_cycle: got %h want %h", a_data(0), exp_data(5, 1));
        end
        checks++;
        if (bus_b.rf2id_rs_data_o !== exp_data(5, 0)) begin
            errors++;
            $display("FAIL nobypass_same_cycle: got %h want %h",
                     bus_b.rf2id_rs_data_o, exp_data(5, 0));
        end
        tick();
        idle();
        #2;
        checks++;
        if (a_data(0) !== 32'h12345678 || bus_b.rf2id_rs_data_o !== 32'h12345678) begin
            errors++;
            $display("FAIL write_next_cycle: got %h/%h want 12345678",
                     a_data(0), bus_b.rf2id_rs_data_o);
        end
    endtask

    task automatic test_issue_waw();
        iss_req  = 1'b1;
        iss_addr = 5'd7;
        set_all_ports(5'd7);
        #2;
        checks++;
        if (bus_a.rf2id_issue_stall_o !== 1'b0) begin
            errors++;
            $display("FAIL issue_first_stall: got %b want 0", bus_a.rf2id_issue_stall_o);
        end
        tick();
        iss_req = 1'b0;
        #2;
        checks++;
        if (bus_a.rf2id_rs_busy_o[0] !== 1'b1 || bus_a.rf2id_busy_cnt_o !== exp_cnt()) begin
            errors++;
            $display("FAIL issue_busy: got %b/%0d want 1/%0d",
                     bus_a.rf2id_rs_busy_o[0], bus_a.rf2id_busy_cnt_o, exp_cnt());
        end
        iss_req = 1'b1;
        #1;
        checks++;
        if (bus_a.rf2id_issue_stall_o !== 1'b1 || bus_b.rf2id_issue_stall_o !== 1'b1) begin
            errors++;
            $display("FAIL waw_stall: got %b/%b want 1",
                     bus_a.rf2id_issue_stall_o, bus_b.rf2id_issue_stall_o);
        end
        tick();
        iss_req = 1'b0;
        #2;
        checks++;
        if (bus_a.rf2id_busy_cnt_o !== 6'd1) begin
            errors++;
            $display("FAIL waw_cnt: got %0d want 1", bus_a.rf2id_busy_cnt_o);
        end
        wr_req  = 1'b1;
        wr_addr = 5'd7;
        wr_data = 32'hA5;
        #1;
        checks++;
        if (bus_a.rf2id_rs_busy_o[0] !== 1'b0 || bus_b.rf2id_rs_busy_o[0] !== 1'b1) begin
            errors++;
            $display("FAIL wb_busy_same_cycle: got %b/%b want 0/1",
                     bus_a.rf2id_rs_busy_o[0], bus_b.rf2id_rs_busy_o[0]);
        end
        tick();
        idle();
        #2;
        checks++;
        if (bus_a.rf2id_rs_busy_o[0] !== 1'b0 || bus_a.rf2id_busy_cnt_o !== 6'd0
            || a_data(0) !== 32'hA5) begin
            errors++;
            $display("FAIL wb_clear: got %b/%0d/%h want 0/0/a5",
                     bus_a.rf2id_rs_busy_o[0], bus_a.rf2id_busy_cnt_o, a_data(0));
        end
    endtask

    task automatic test_same_cycle();
        iss_req  = 1'b1;
        iss_addr = 5'd9;
        set_all_ports(5'd9);
        tick();
        wr_req  = 1'b1;
        wr_addr = 5'd9;
        wr_data = 32'h11;
        #2;
        checks++;
        if (bus_a.rf2id_issue_stall_o !== exp_stall() || bus_a.rf2id_issue_stall_o !== 1'b0) begin
            errors++;
            $display("FAIL setclr_stall: got %b want 0", bus_a.rf2id_issue_stall_o);
        end
        tick();
        idle();
        #2;
        checks++;
        if (bus_a.rf2id_rs_busy_o[0] !== 1'b1 || bus_a.rf2id_busy_cnt_o !== 6'd1
            || a_data(0) !== 32'h11) begin
            errors++;
            $display("FAIL setclr_result: got %b/%0d/%h want 1/1/11",
                     bus_a.rf2id_rs_busy_o[0], bus_a.rf2id_busy_cnt_o, a_data(0));
        end
        wr_req = 1'b1;
        tick();
        idle();
    endtask

    task automatic test_back_to_back();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int r = 1; r < NREGS; r++) begin
            iss_req  = 1'b1;
            iss_addr = AW'(r);
            #2;
            checks++;
            if (bus_a.rf2id_issue_stall_o !== 1'b0) begin
                errors++;
                $display("FAIL b2b_stall x%0d: got %b want 0", r, bus_a.rf2id_issue_stall_o);
            end
            tick();
        end
        idle();
        #2;
        checks++;
        if (bus_a.rf2id_busy_cnt_o !== 6'd31 || bus_b.rf2id_busy_cnt_o !== exp_cnt()) begin
            errors++;
            $display("FAIL b2b_cnt: got %0d/%0d want 31",
                     bus_a.rf2id_busy_cnt_o, bus_b.rf2id_busy_cnt_o);
        end
        reset    = 1'b1;
        wr_req   = 1'b1;
        wr_addr  = 5'd4;
        wr_data  = 32'hCAFEF00D;
        iss_req  = 1'b1;
        iss_addr = 5'd2;
        tick();
        reset = 1'b0;
        idle();
        for (int a = 0; a < NREGS; a++) begin
            set_all_ports(AW'(a));
            #2;
            checks++;
            if (a_data(0) !== 32'h0 || bus_a.rf2id_rs_busy_o !== 4'h0
                || bus_a.rf2id_busy_cnt_o !== 6'd0) begin
                errors++;
                $display("FAIL reset_over_pending x%0d: got %h/%h/%0d want 0/0/0",
                         a, a_data(0), bus_a.rf2id_rs_busy_o, bus_a.rf2id_busy_cnt_o);
            end
            tick();
        end
    endtask

    task automatic test_nrd4();
        logic [XLEN-1:0] want [NRD];
        want[0] = 32'h33;
        want[1] = 32'h33;
        want[2] = 32'h0;
        want[3] = 32'hFFFFFFFF;
        wr_req  = 1'b1;
        wr_addr = 5'd3;
        wr_data = 32'h33;
        tick();
        wr_addr = 5'd31;
        wr_data = 32'hFFFFFFFF;
        tick();
        idle();
        rs_addr = {5'd31, 5'd0, 5'd3, 5'd3};
        #2;
        for (int k = 0; k < NRD; k++) begin
            checks++;
            if (a_data(k) !== want[k]) begin
                errors++;
                $display("FAIL nrd4 p%0d: got %h want %h", k, a_data(k), want[k]);
            end
        end
    endtask

    task automatic test_random();
        logic [AW-1:0] a;
        for (int n = 0; n < 600; n++) begin
            reset    = ($urandom_range(0, 59) == 0);
            wr_req   = $urandom_range(0, 1) == 1;
            wr_addr  = AW'($urandom_range(0, 7));
            wr_data  = $urandom;
            iss_req  = $urandom_range(0, 2) != 0;
            iss_addr = AW'($urandom_range(0, 7));
            for (int k = 0; k < NRD; k++) rs_addr[k*AW +: AW] = AW'($urandom_range(0, 9));
            #2;
            for (int k = 0; k < NRD; k++) begin
                a = rs_addr[k*AW +: AW];
                checks++;
                if (a_data(k) !== exp_data(a, 1)
                    || bus_a.rf2id_rs_busy_o[k] !== exp_busy(a, 1)) begin
                    errors++;
                    $display("FAIL rand_a n%0d p%0d x%0d: got %h/%b want %h/%b", n, k, a,
                             a_data(k), bus_a.rf2id_rs_busy_o[k], exp_data(a, 1), exp_busy(a, 1));
                end
            end
            a = rs_addr[AW-1:0];
            checks++;
            if (bus_b.rf2id_rs_data_o !== exp_data(a, 0)
                || bus_b.rf2id_rs_busy_o[0] !== exp_busy(a, 0)) begin
                errors++;
                $display("FAIL rand_b n%0d x%0d: got %h/%b want %h/%b", n, a,
                         bus_b.rf2id_rs_data_o, bus_b.rf2id_rs_busy_o[0],
                         exp_data(a, 0), exp_busy(a, 0));
            end
            checks++;
            if (bus_a.rf2id_issue_stall_o !== exp_stall()
                || bus_b.rf2id_issue_stall_o !== exp_stall()
                || bus_a.rf2id_busy_cnt_o !== exp_cnt()
                || bus_b.rf2id_busy_cnt_o !== exp_cnt()) begin
                errors++;
                $display("FAIL rand_sb n%0d: stall %b/%b cnt %0d/%0d want %b/%0d", n,
                         bus_a.rf2id_issue_stall_o, bus_b.rf2id_issue_stall_o,
                         bus_a.rf2id_busy_cnt_o, bus_b.rf2id_busy_cnt_o,
                         exp_stall(), exp_cnt());
            end
            tick();
        end
        reset = 1'b0;
        idle();
    endtask

    initial begin
        reset    = 1'b1;
        rs_addr  = '0;
        wr_req   = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        iss_req  = 1'b0;
        iss_addr = '0;
        for (int i = 0; i < NREGS; i++) begin
            m_reg[i]  = '0;
            m_busy[i] = 1'b0;
        end
        test_reset();
        test_bypass();
        test_issue_waw();
        test_same_cycle();
        test_back_to_back();
        test_nrd4();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
